// File: rtl/alarm_key_fsm_pkg.sv
// Shared definitions for the alarm-clock key-entry path: state encodings,
// the keypad "no key" code and the default entry timeout.
package alarm_key_fsm_pkg;

    typedef enum logic [2:0] {
        SHOW_TIME  = 3'd0,
        SHOW_ALARM = 3'd1,
        KEY_STORED = 3'd2,
        KEY_WAITED = 3'd3,
        KEY_ENTRY  = 3'd4,
        SET_ALARM  = 3'd5,
        SET_TIME   = 3'd6
    } state_t;

    localparam logic [3:0] NOKEY = 4'd10;
    localparam int TIMEOUT_SECS_DEFAULT = 10;

    // Codes above 9 all mean "no key".
    function automatic logic key_is_valid(input logic [3:0] code);
        return (code < NOKEY);
    endfunction

endpackage

// File: rtl/alarm_key_fsm_key_timeout_timer.sv
// Saturating seconds counter that flags when key entry has been idle too long.
module key_timeout_timer
    import alarm_key_fsm_pkg::*;
#(
    parameter int TIMEOUT_SECS = TIMEOUT_SECS_DEFAULT
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic one_second,
    input  logic enable,
    output logic timeout
);

    localparam int CW = $clog2(TIMEOUT_SECS + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_SECS);

    logic [CW-1:0] count_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable && one_second && (count_reg != LAST)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    // A saturated count still fires on the next pulse, so entry can never stall.
    assign timeout = enable && one_second && (count_reg >= (LAST - 1'b1));

endmodule

// File: rtl/alarm_key_fsm.sv
// Key-entry controller for the alarm clock: sequences digit entry, selects
// what the LCD shows and strobes the key buffer and alarm/time registers.
module alarm_key_fsm
    import alarm_key_fsm_pkg::*;
#(
    parameter int TIMEOUT_SECS = TIMEOUT_SECS_DEFAULT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       one_second,
    input  logic [3:0] key,
    input  logic       alarm_button,
    input  logic       time_button,
    output logic       show_a,
    output logic       show_new_time,
    output logic       shift,
    output logic       load_new_a,
    output logic       load_new_c
);

    state_t state_reg, state_next;
    logic   key_valid;
    logic   in_entry;
    logic   timeout;

    assign key_valid = key_is_valid(key);
    assign in_entry  = (state_reg == KEY_WAITED) || (state_reg == KEY_ENTRY);

    key_timeout_timer #(
        .TIMEOUT_SECS(TIMEOUT_SECS)
    ) u_timer (
        .clock      (clock),
        .reset      (reset),
        .clear      (!in_entry),
        .one_second (one_second),
        .enable     (in_entry),
        .timeout    (timeout)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= SHOW_TIME;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        show_a        = 1'b0;
        show_new_time = 1'b0;
        shift         = 1'b0;
        load_new_a    = 1'b0;
        load_new_c    = 1'b0;
        case (state_reg)
            SHOW_TIME: begin
                if (alarm_button)   state_next = SHOW_ALARM;
                else if (key_valid) state_next = KEY_STORED;
            end
            SHOW_ALARM: begin
                show_a = 1'b1;
                if (!alarm_button) state_next = SHOW_TIME;
            end
            KEY_STORED: begin
                shift         = 1'b1;
                show_new_time = 1'b1;
                state_next    = KEY_WAITED;
            end
            // Wait for the digit to be released so a held key shifts once.
            KEY_WAITED: begin
                show_new_time = 1'b1;
                if (!key_valid)   state_next = KEY_ENTRY;
                else if (timeout) state_next = SHOW_TIME;
            end
            KEY_ENTRY: begin
                show_new_time = 1'b1;
                if (alarm_button)     state_next = SET_ALARM;
                else if (time_button) state_next = SET_TIME;
                else if (key_valid)   state_next = KEY_STORED;
                else if (timeout)     state_next = SHOW_TIME;
            end
            SET_ALARM: begin
                load_new_a = 1'b1;
                state_next = SHOW_TIME;
            end
            SET_TIME: begin
                load_new_c = 1'b1;
                state_next = SHOW_TIME;
            end
            default: state_next = SHOW_TIME;
        endcase
    end

endmodule
